// File: rtl/pkt_len_sum_collector.sv
// -----------------------------------------------------------------------------
// pkt_len_sum_collector
//
// Collects per-packet statistics from a valid/last framed stream. The input
// side has no ready; every beat presented with up_valid=1 is consumed. For
// each packet the block counts beats and sums the data words, both
// saturating. On the last beat the {len, sum} record is pushed into a small
// result FIFO that drains through a valid/ready output, so a slow sink never
// stalls the stream. If the FIFO is full and nothing pops in that cycle, the
// new record is dropped and the sticky overflow flag is set.
//
// Optional build macro: PKT_LEN_SUM_COLLECTOR_MAX_EN
//   When defined, each record also carries the largest data word of the
//   packet on down_max. When undefined, the port and its storage are absent.
//
// Ports:
//   clock       in   clock
//   reset       in   synchronous active-high reset
//   up_valid    in   input beat valid
//   up_last     in   last beat of packet (qualified by up_valid)
//   up_data     in   beat data [width-1:0] (qualified by up_valid)
//   down_valid  out  result record available (FIFO not empty)
//   down_ready  in   sink accepts the head record
//   down_len    out  packet length in beats [len_width-1:0], 0 when !down_valid
//   down_sum    out  packet data sum [sum_width-1:0], 0 when !down_valid
//   down_max    out  (optional) packet max data [width-1:0], 0 when !down_valid
//   overflow    out  sticky: a record was dropped because the FIFO was full
//
// Output handshake: down_valid is high whenever a record sits at the FIFO
// head; the head record is transferred (popped) on a cycle where both
// down_valid and down_ready are high. While down_valid=1 and down_ready=0 the
// head record is held stable. down_ready has no effect while down_valid=0.
// -----------------------------------------------------------------------------
module pkt_len_sum_collector #(
    parameter int width      = 8,
    parameter int len_width  = 8,
    parameter int sum_width  = 16,
    parameter int fifo_depth = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 up_valid,
    input  logic                 up_last,
    input  logic [width-1:0]     up_data,
    output logic                 down_valid,
    input  logic                 down_ready,
    output logic [len_width-1:0] down_len,
    output logic [sum_width-1:0] down_sum,
`ifdef PKT_LEN_SUM_COLLECTOR_MAX_EN
    output logic [width-1:0]     down_max,
`endif
    output logic                 overflow
);

    localparam int ptr_w = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int cnt_w = $clog2(fifo_depth + 1);
    localparam logic [cnt_w-1:0] depth_c = cnt_w'(fifo_depth);

    // ---------------------------------------------------------------------
    // Accumulators and the per-beat saturated results
    // ---------------------------------------------------------------------
    logic [len_width-1:0] len_acc_q, len_acc_d;
    logic [sum_width-1:0] sum_acc_q, sum_acc_d;
    logic [len_width:0]   len_inc;
    logic [sum_width:0]   sum_inc;
    logic [len_width-1:0] beat_len;
    logic [sum_width-1:0] beat_sum;

    // One extra carry bit detects the clamp condition; a set carry means the
    // true value exceeded all-ones, so the result sticks at all-ones.
    always_comb begin
        len_inc  = {1'b0, len_acc_q} + (len_width+1)'(1);
        sum_inc  = {1'b0, sum_acc_q} + (sum_width+1)'(up_data);
        beat_len = len_inc[len_width] ? {len_width{1'b1}} : len_inc[len_width-1:0];
        beat_sum = sum_inc[sum_width] ? {sum_width{1'b1}} : sum_inc[sum_width-1:0];
    end

`ifdef PKT_LEN_SUM_COLLECTOR_MAX_EN
    logic [width-1:0] max_acc_q, max_acc_d;
    logic [width-1:0] beat_max;

    // Accumulator restarts at 0 per packet, so the first beat always wins.
    always_comb begin
        beat_max = (up_data > max_acc_q) ? up_data : max_acc_q;
    end
`endif

    // ---------------------------------------------------------------------
    // FIFO control
    // ---------------------------------------------------------------------
    logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [cnt_w-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    always_comb begin
        push_req   = up_valid & up_last;
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == depth_c);
        pop        = ~fifo_empty & down_ready;
        // A full FIFO still accepts a push when the head leaves in the same
        // cycle, because the slot being written is the one just freed.
        push       = push_req & (~fifo_full | pop);
    end

    always_comb begin
        len_acc_d  = len_acc_q;
        sum_acc_d  = sum_acc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (up_valid) begin
            if (up_last) begin
                // Accumulators clear whether or not the record is stored.
                len_acc_d = '0;
                sum_acc_d = '0;
            end else begin
                len_acc_d = beat_len;
                sum_acc_d = beat_sum;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + ptr_w'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_w'(1);
        end
        if (push && !pop) begin
            count_d = count_q + cnt_w'(1);
        end else if (pop && !push) begin
            count_d = count_q - cnt_w'(1);
        end

        if (push_req && !push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            len_acc_q  <= '0;
            sum_acc_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            len_acc_q  <= len_acc_d;
            sum_acc_q  <= sum_acc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // ---------------------------------------------------------------------
    // FIFO storage. Contents need no reset: the count gates visibility.
    // ---------------------------------------------------------------------
    logic [len_width-1:0] mem_len_q [fifo_depth];
    logic [len_width-1:0] mem_len_d [fifo_depth];
    logic [sum_width-1:0] mem_sum_q [fifo_depth];
    logic [sum_width-1:0] mem_sum_d [fifo_depth];

    always_comb begin
        mem_len_d = mem_len_q;
        mem_sum_d = mem_sum_q;
        if (push) begin
            mem_len_d[wr_ptr_q] = beat_len;
            mem_sum_d[wr_ptr_q] = beat_sum;
        end
    end

    always_ff @(posedge clock) begin
        mem_len_q <= mem_len_d;
        mem_sum_q <= mem_sum_d;
    end

`ifdef PKT_LEN_SUM_COLLECTOR_MAX_EN
    logic [width-1:0] mem_max_q [fifo_depth];
    logic [width-1:0] mem_max_d [fifo_depth];

    always_comb begin
        max_acc_d = max_acc_q;
        if (up_valid) begin
            max_acc_d = up_last ? '0 : beat_max;
        end
        mem_max_d = mem_max_q;
        if (push) begin
            mem_max_d[wr_ptr_q] = beat_max;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            max_acc_q <= '0;
        end else begin
            max_acc_q <= max_acc_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_max_q <= mem_max_d;
    end
`endif

    // ---------------------------------------------------------------------
    // Outputs: head record, forced to zero while the FIFO is empty
    // ---------------------------------------------------------------------
    always_comb begin
        down_valid = ~fifo_empty;
        down_len   = fifo_empty ? '0 : mem_len_q[rd_ptr_q];
        down_sum   = fifo_empty ? '0 : mem_sum_q[rd_ptr_q];
`ifdef PKT_LEN_SUM_COLLECTOR_MAX_EN
        down_max   = fifo_empty ? '0 : mem_max_q[rd_ptr_q];
`endif
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_pkt_len_sum_collector.sv
// -----------------------------------------------------------------------------
// Bench for pkt_len_sum_collector. A packet-level model keeps the running
// length/sum/max as plain integers and holds completed records in a bounded
// queue; outputs are compared against that model one time unit after every
// rising clock edge.
// -----------------------------------------------------------------------------
module tb_pkt_len_sum_collector;

    localparam int W     = 8;
    localparam int LEN_W = 8;
    localparam int SUM_W = 16;
    localparam int DEPTH = 4;
    localparam int LEN_MAX = (1 << LEN_W) - 1;
    localparam int SUM_MAX = (1 << SUM_W) - 1;
    localparam int REC_W = LEN_W + SUM_W + W;

    // ---------------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------------
    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             up_valid = 1'b0;
    logic             up_last = 1'b0;
    logic [W-1:0]     up_data = '0;
    logic             down_valid;
    logic             down_ready = 1'b0;
    logic [LEN_W-1:0] down_len;
    logic [SUM_W-1:0] down_sum;
    logic             overflow;
`ifdef PKT_LEN_SUM_COLLECTOR_MAX_EN
    logic [W-1:0]     down_max;
`endif

    always #5 clock = ~clock;

    pkt_len_sum_collector #(
        .width(W), .len_width(LEN_W), .sum_width(SUM_W), .fifo_depth(DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .up_valid   (up_valid),
        .up_last    (up_last),
        .up_data    (up_data),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_len   (down_len),
        .down_sum   (down_sum),
`ifdef PKT_LEN_SUM_COLLECTOR_MAX_EN
        .down_max   (down_max),
`endif
        .overflow   (overflow)
    );

    // ---------------------------------------------------------------------
    // Scoreboard / reference model
    // ---------------------------------------------------------------------
    logic [REC_W-1:0] exp_q[$];   // {len, sum, max}
    int  m_len;
    int  m_sum;
    int  m_max;
    bit  m_ovf;
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // Apply the current inputs to the model, advance one clock, then compare.
    task automatic step();
        logic [REC_W-1:0] rec;
        int  l, s, mx;
        bit  pop;
        if (reset) begin
            exp_q.delete();
            m_len = 0;
            m_sum = 0;
            m_max = 0;
            m_ovf = 1'b0;
        end else begin
            pop = (exp_q.size() != 0) && down_ready;
            if (pop) void'(exp_q.pop_front());
            if (up_valid) begin
                l  = sat(m_len + 1, LEN_MAX);
                s  = sat(m_sum + int'(up_data), SUM_MAX);
                mx = (int'(up_data) > m_max) ? int'(up_data) : m_max;
                if (up_last) begin
                    rec = {LEN_W'(l), SUM_W'(s), W'(mx)};
                    if (exp_q.size() < DEPTH) exp_q.push_back(rec);
                    else m_ovf = 1'b1;
                    m_len = 0;
                    m_sum = 0;
                    m_max = 0;
                end else begin
                    m_len = l;
                    m_sum = s;
                    m_max = mx;
                end
            end
        end
        @(posedge clock);
        #1;
        compare_outputs();
    endtask

    task automatic compare_outputs();
        logic [REC_W-1:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : '0;
        check("valid", 32'(down_valid), 32'(exp_q.size() != 0));
        check("len", 32'(down_len), 32'(head[REC_W-1 -: LEN_W]));
        check("sum", 32'(down_sum), 32'(head[W +: SUM_W]));
`ifdef PKT_LEN_SUM_COLLECTOR_MAX_EN
        check("max", 32'(down_max), 32'(head[W-1:0]));
`endif
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // ---------------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------------
    task automatic do_reset();
        reset    = 1'b1;
        up_valid = 1'b0;
        up_last  = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic beat(input logic [W-1:0] d, input bit last);
        up_valid = 1'b1;
        up_last  = last;
        up_data  = d;
        step();
        up_valid = 1'b0;
        up_last  = 1'b0;
        up_data  = $urandom_range(0, 255);  // ignored while idle
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            up_valid = 1'b0;
            up_last  = $urandom_range(0, 1);
            step();
        end
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        m_len = 0; m_sum = 0; m_max = 0; m_ovf = 1'b0;
        do_reset();
        check("rst_valid", 32'(down_valid), 32'd0);
        check("rst_len", 32'(down_len), 32'd0);
        check("rst_sum", 32'(down_sum), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // Single-beat packet
        down_ready = 1'b1;
        beat(8'h05, 1'b1);
        check("single_valid", 32'(down_valid), 32'd1);
        check("single_len", 32'(down_len), 32'd1);
        check("single_sum", 32'(down_sum), 32'h5);
        idle(1);
        check("single_drained", 32'(down_valid), 32'd0);

        // Packet with idle gaps
        beat(8'h10, 1'b0);
        idle(2);
        beat(8'h20, 1'b0);
        idle(1);
        check("gap_pending", 32'(down_valid), 32'd0);
        beat(8'h30, 1'b1);
        check("gap_len", 32'(down_len), 32'd3);
        check("gap_sum", 32'(down_sum), 32'h60);
        idle(1);

        // Backpressure and overflow
        down_ready = 1'b0;
        for (int i = 1; i <= 5; i++) beat(W'(i), 1'b1);
        check("ovf_set", 32'(overflow), 32'd1);
        down_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_sum", 32'(down_sum), 32'(i));
            idle(1);
        end
        check("drain_empty", 32'(down_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO with a pop in the same cycle as the push
        do_reset();
        down_ready = 1'b0;
        for (int i = 1; i <= 4; i++) beat(W'(i), 1'b1);
        down_ready = 1'b1;
        beat(8'h09, 1'b1);
        down_ready = 1'b0;
        check("fullpop_ovf", 32'(overflow), 32'd0);
        check("fullpop_head", 32'(down_sum), 32'd2);
        idle(2);
        down_ready = 1'b1;
        idle(5);

        // Saturation
        for (int i = 0; i < 299; i++) beat(8'hFF, 1'b0);
        beat(8'hFF, 1'b1);
        check("sat_len", 32'(down_len), 32'd255);
        check("sat_sum", 32'(down_sum), 32'hFFFF);
        idle(1);

        // Reset mid-packet
        beat(8'h01, 1'b0);
        beat(8'h01, 1'b0);
        do_reset();
        check("midrst_empty", 32'(down_valid), 32'd0);
        beat(8'h07, 1'b1);
        check("midrst_len", 32'(down_len), 32'd1);
        check("midrst_sum", 32'(down_sum), 32'd7);
        idle(1);

`ifdef PKT_LEN_SUM_COLLECTOR_MAX_EN
        beat(8'h03, 1'b0);
        beat(8'h09, 1'b0);
        beat(8'h04, 1'b1);
        check("max_pkt", 32'(down_max), 32'd9);
        idle(1);
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 399) == 0);
            up_valid   = ($urandom_range(0, 3) != 0);
            up_last    = ($urandom_range(0, 4) == 0);
            up_data    = W'($urandom_range(0, 255));
            down_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
